mips_bus_arbiter: RTL and testbench
===================================

Name: mips_bus_arbiter

Overview:
Two-master, one-slave arbiter for the CPU memory bus: address, read, write, writedata, byteenable, readdata, waitrequest. Master 0 is the instruction-fetch port and master 1 is the load/store port of mips_cpu_bus. The single slave is the RAM/memory bus. Arbitration is round-robin with grant parking, plus a per-transfer watchdog that terminates hung transfers with an error pulse.

Parameters:
TIMEOUT_CYCLES, 256, consecutive stalled cycles (request held, s_waitrequest=1) before the watchdog aborts the transfer; legal range 2..65535.
ERR_READDATA, 32'hDEADBEEF, readdata returned to the master on a watchdog abort.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
m0_address / m1_address  in  32  master byte address
m0_read / m1_read  in  1  read request
m0_write / m1_write  in  1  write request
m0_writedata / m1_writedata  in  32  write data
m0_byteenable / m1_byteenable  in  4  byte lanes
m0_readdata / m1_readdata  out  32  read data to master
m0_waitrequest / m1_waitrequest  out  1  stall to master
m0_err / m1_err  out  1  one-cycle watchdog abort pulse
s_address  out  32  slave address
s_read, s_write  out  1  slave strobes
s_writedata  out  32  slave write data
s_byteenable  out  4  slave byte lanes
s_readdata  in  32  slave read data
s_waitrequest  in  1  slave stall
grant  out  2  one-hot owner: 01 = M0, 10 = M1, 00 = none

Behaviour:
- req_x = mx_read | mx_write. Masters hold all request signals stable while their waitrequest=1. The arbiter latches nothing from masters; the owner is muxed to the slave combinationally.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - No request: stay in IDLE.
  - One request: go to that master's OWN state next cycle.
  - Both requesting: go to the master not served last (rr pointer).
  - Arbitration latency from IDLE is 1 cycle. s_read and s_write are 0 in IDLE.
- OWNx:
  - Slave outputs = master x's signals. mx_waitrequest = s_waitrequest. mx_readdata = s_readdata.
  - A transfer completes when req_x=1 and s_waitrequest=0. On completion the rr pointer is set to x.
  - After completion: if the other master is requesting, move to OWN(other) next cycle (no idle cycle). Otherwise stay in OWNx (parked), so back-to-back transfers from x run at full rate.
  - Parked with req_x=0 and the other master requesting: move to OWN(other) next cycle.
  - Parked with req_x=0 and no other request: stay parked (not IDLE).
- Non-owner master: waitrequest=1 and readdata=0 at all times.
- Simultaneous read and write from one master is illegal. The arbiter forwards both strobes unchanged and does not check this.
- Watchdog:
  - Counter clears on every completion, every grant change, and whenever the owner is not requesting.
  - Counter increments each OWN cycle with req=1 and s_waitrequest=1.
  - When the counter reaches TIMEOUT_CYCLES-1 and the slave still stalls, the next cycle is an abort cycle:
    - mx_waitrequest=0, mx_readdata=ERR_READDATA, mx_err=1 for exactly 1 cycle.
    - s_read and s_write are forced to 0 in the abort cycle.
  - The abort is treated as a completion for FSM and rr purposes.
  - Counter width = $clog2(TIMEOUT_CYCLES)+1.
- Reset (reset=0, asynchronous):
  - State IDLE; rr pointer set so M0 wins the first tie; counter 0.
  - Outputs: s_read=0, s_write=0, s_address=0, s_writedata=0, s_byteenable=0; m0/m1_waitrequest=1, readdata=0, err=0; grant=00.
  - Reset asserted mid-transfer drops the slave strobes in the same cycle, with no clock edge needed. The interrupted transfer is lost, and the master re-issues after reset.

Decomposition:
- Package mips_bus_pkg:
  - state enum {IDLE, OWN0, OWN1}
  - DEFAULT_TIMEOUT = 256
  - ERR_DATA = 32'hDEADBEEF
  - a bus-request struct {address, read, write, writedata, byteenable}, shared with mips_cpu_bus
- Sub-module bus_watchdog: clk, reset, clear, stall inputs; expired output; parameter TIMEOUT_CYCLES. The arbiter instantiates one and time-shares it, since only one transfer is ever outstanding.

Test Plan:
1. M0 read at 32'hBFC00000, slave waitrequest=0, s_readdata=32'h00001234 -> grant=01 one cycle after request; s_read=1, s_address=BFC00000; m0_readdata=00001234 with m0_waitrequest=0 in that cycle.
2. After reset, M0 read and M1 write both requested continuously for 4 transfers each -> grant sequence M0, M1, M0, M1, …; no idle cycle between transfers; each master waitrequest=1 while not owner.
3. M1 alone issues 3 back-to-back writes (byteenable 4'b0011, data 32'hCAFE0001..3) -> parked in OWN1; 3 completions on 3 consecutive slave-ready cycles; s_byteenable=0011 passed through unchanged.
4. TIMEOUT_CYCLES=16; M0 read with s_waitrequest stuck at 1 -> after 16 stalled cycles: m0_err=1 for 1 cycle, m0_readdata=DEADBEEF, m0_waitrequest=0, s_read=0; then a pending M1 request is granted.
5. reset driven to 0 mid M1 write with slave stalling -> s_write=0 and grant=00 immediately (before the next edge); after release with both masters requesting, M0 is granted first.
6. Slave waitrequest toggling 1,0 on alternate cycles with both masters reading -> every completion returns the correct s_readdata to the owner only; the non-owner's readdata stays 0 throughout.

Source files
------------

// File: rtl/mips_bus_arbiter_pkg.sv
// Shared types and constants for the CPU memory-bus arbiter.
// The request struct is the same bundle mips_cpu_bus drives on each of its ports.
package mips_bus_pkg;

  // Arbiter ownership state: nobody, instruction-fetch port, load/store port
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Stalled cycles tolerated before a hung transfer is aborted
  localparam int DEFAULT_TIMEOUT = 256;

  // Recognisable poison value handed back to a master on an aborted read
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  // One master's request bundle towards the memory bus
  typedef struct packed {
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
  } bus_req_t;

  // A master is asking for the bus when either strobe is up
  function automatic logic bus_req_active(input bus_req_t r);
    return r.read | r.write;
  endfunction

endpackage

// File: rtl/mips_bus_arbiter_watchdog.sv
// Stall watchdog for the single outstanding bus transfer.
// Counts consecutive stalled cycles and raises 'expired' for the cycle that
// follows the last tolerated stall; the owner of 'clear' decides when a new
// transfer begins.
module bus_watchdog
  import mips_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;
  logic          at_limit;

  assign at_limit = (count == LAST_COUNT);

  // Stall counter: restarts on clear, saturates once the limit is reached
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (stall && !at_limit) begin
      count <= count + CW'(1);
    end
  end

  // Abort flag for the cycle after the final tolerated stall; clear suppresses it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expired <= 1'b0;
    end else begin
      expired <= !clear && stall && at_limit;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the CPU memory bus.
// Master 0 is instruction fetch, master 1 is load/store. The owner is muxed
// combinationally onto the slave; ownership is parked with the last user so a
// lone master streams at full rate. A time-shared watchdog aborts hung
// transfers with a one-cycle error pulse and poison read data.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter logic [31:0] ERR_READDATA   = ERR_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic [31:0] m0_readdata,
  output logic        m0_waitrequest,
  output logic        m0_err,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic [31:0] m1_readdata,
  output logic        m1_waitrequest,
  output logic        m1_err,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic [31:0] s_readdata,
  input  logic        s_waitrequest,
  output logic [1:0]  grant
);

  arb_state_t state, state_next;
  bus_req_t   m0_req, m1_req, owner_req;
  logic       req0, req1;
  logic       owner_active;
  logic       owner_requesting;
  logic       abort;
  logic       complete;
  logic       wd_clear, wd_stall, wd_expired;
  logic       rr_last;  // 1: master 1 was served most recently, so master 0 wins a tie

  assign m0_req = '{address: m0_address, read: m0_read, write: m0_write,
                    writedata: m0_writedata, byteenable: m0_byteenable};
  assign m1_req = '{address: m1_address, read: m1_read, write: m1_write,
                    writedata: m1_writedata, byteenable: m1_byteenable};

  assign req0 = bus_req_active(m0_req);
  assign req1 = bus_req_active(m1_req);

  // Select the current owner's request bundle; nothing reaches the slave in IDLE
  always_comb begin
    owner_req = '0;
    case (state)
      OWN0:    owner_req = m0_req;
      OWN1:    owner_req = m1_req;
      default: owner_req = '0;
    endcase
  end

  assign owner_active     = (state == OWN0) || (state == OWN1);
  assign owner_requesting = owner_active && bus_req_active(owner_req);

  // An abort is only meaningful while the owner still holds its request
  assign abort    = wd_expired && owner_requesting;
  assign complete = owner_requesting && (!s_waitrequest || abort);

  // Any completion or idle owner starts a fresh timeout window; grant changes
  // only ever follow one of those, so they are covered too
  assign wd_clear = !owner_requesting || complete;
  assign wd_stall = owner_requesting && s_waitrequest && !abort;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .stall  (wd_stall),
    .expired(wd_expired)
  );

  // Ownership state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Round-robin pointer: remember who finished (or was aborted) last
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last <= 1'b1;
    end else if (complete) begin
      rr_last <= (state == OWN1);
    end
  end

  // Next owner: hand over only at a transfer boundary or when the owner is idle
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          state_next = rr_last ? OWN0 : OWN1;
        end else if (req0) begin
          state_next = OWN0;
        end else if (req1) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        if ((complete || !req0) && req1) begin
          state_next = OWN1;
        end
      end
      OWN1: begin
        if ((complete || !req1) && req0) begin
          state_next = OWN0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus steering: owner sees the slave, non-owner is held off with zero data
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_readdata    = '0;
    m0_waitrequest = 1'b1;
    m0_err         = 1'b0;
    m1_readdata    = '0;
    m1_waitrequest = 1'b1;
    m1_err         = 1'b0;
    grant          = 2'b00;

    if (owner_active) begin
      s_address    = owner_req.address;
      s_read       = owner_req.read && !abort;
      s_write      = owner_req.write && !abort;
      s_writedata  = owner_req.writedata;
      s_byteenable = owner_req.byteenable;
    end

    case (state)
      OWN0: begin
        grant          = 2'b01;
        m0_waitrequest = abort ? 1'b0 : s_waitrequest;
        m0_readdata    = abort ? ERR_READDATA : s_readdata;
        m0_err         = abort;
      end
      OWN1: begin
        grant          = 2'b10;
        m1_waitrequest = abort ? 1'b0 : s_waitrequest;
        m1_readdata    = abort ? ERR_READDATA : s_readdata;
        m1_err         = abort;
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: two queue-driven master models,
// a behavioural slave, and a scoreboard of expected completions in order.
module tb_mips_bus_arbiter;
  import mips_bus_pkg::*;

  localparam int TO = 16;

  logic        clk, reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest, m0_err, m1_err;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } cmd_t;

  typedef struct {
    int          master;
    logic        write;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } exp_t;

  cmd_t m0_cmds[$];
  cmd_t m1_cmds[$];
  exp_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   wait_mode = 0;  // 0 ready, 1 stuck, 2 alternate
  int   last_comp = 0;
  logic have_last = 1'b0;
  logic check_gap = 1'b0;
  logic [1:0]  smp_grant;
  logic        smp_read, smp_err0;
  logic [31:0] smp_addr;

  mips_bus_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .ERR_READDATA  (32'hDEADBEEF)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest), .m0_err(m0_err),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest), .m1_err(m1_err),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave memory model: data is a fixed function of the address
  function automatic logic [31:0] slave_map(input logic [31:0] a);
    return (a == 32'hBFC00000) ? 32'h00001234 : (a ^ 32'hA5A5A5A5);
  endfunction

  assign s_readdata = slave_map(s_address);

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  // Drive each master from the head of its command queue, and the slave stall
  task automatic applyStimulus();
    if (m0_cmds.size() > 0) begin
      m0_read = !m0_cmds[0].write; m0_write = m0_cmds[0].write;
      m0_address = m0_cmds[0].addr; m0_writedata = m0_cmds[0].data;
      m0_byteenable = m0_cmds[0].be;
    end else begin
      m0_read = 0; m0_write = 0; m0_address = 0; m0_writedata = 0; m0_byteenable = 0;
    end
    if (m1_cmds.size() > 0) begin
      m1_read = !m1_cmds[0].write; m1_write = m1_cmds[0].write;
      m1_address = m1_cmds[0].addr; m1_writedata = m1_cmds[0].data;
      m1_byteenable = m1_cmds[0].be;
    end else begin
      m1_read = 0; m1_write = 0; m1_address = 0; m1_writedata = 0; m1_byteenable = 0;
    end
    s_waitrequest = (wait_mode == 1) || (wait_mode == 2 && cycle[0]);
  endtask

  function automatic cmd_t mk_cmd(input logic write, input logic [31:0] addr,
                                  input logic [31:0] data, input logic [3:0] be);
    cmd_t c;
    c.write = write; c.addr = addr; c.data = data; c.be = be;
    return c;
  endfunction

  function automatic void push_exp(input int master, input cmd_t c, input logic err);
    exp_t e;
    e.master = master; e.write = c.write; e.err = err; e.addr = c.addr;
    e.wdata = c.data; e.be = c.be;
    e.rdata = err ? 32'hDEADBEEF : slave_map(c.addr);
    exp_q.push_back(e);
  endfunction

  task automatic issue(input int master, input logic write, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
    cmd_t c;
    c = mk_cmd(write, addr, data, be);
    if (master == 0) m0_cmds.push_back(c);
    else m1_cmds.push_back(c);
    push_exp(master, c, 1'b0);
    applyStimulus();
  endtask

  task automatic set_wait(input int mode);
    wait_mode = mode;
    applyStimulus();
  endtask

  // Per-master monitor: non-owner hold-off, and scoreboard pop on completion
  task automatic monitor_master(input int x, output logic fin);
    logic        req, wr, er;
    logic [31:0] rd;
    exp_t        e;
    req = (x == 0) ? (m0_read | m0_write) : (m1_read | m1_write);
    wr  = (x == 0) ? m0_waitrequest : m1_waitrequest;
    er  = (x == 0) ? m0_err : m1_err;
    rd  = (x == 0) ? m0_readdata : m1_readdata;
    fin = 1'b0;
    if (!grant[x]) checkOutput((x == 0) ? "nonOwner0" : "nonOwner1", {wr, rd}, {1'b1, 32'h0});
    if (req && !wr) begin
      fin = 1'b1;
      checkOutput("sbPending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("owner", x, e.master);
        checkOutput("grant", grant, (x == 0) ? 2'b01 : 2'b10);
        checkOutput("err", er, e.err);
        if (e.err) begin
          checkOutput("abortStrobes", {s_read, s_write}, 2'b00);
        end else begin
          checkOutput("strobes", {s_read, s_write}, {!e.write, e.write});
          checkOutput("addr", s_address, e.addr);
        end
        if (e.write && !e.err) begin
          checkOutput("wdata", s_writedata, e.wdata);
          checkOutput("be", s_byteenable, e.be);
        end else begin
          checkOutput("rdata", rd, e.rdata);
        end
        if (check_gap && have_last) checkOutput("gap", cycle - last_comp, 1);
        have_last = 1'b1;
        last_comp = cycle;
      end
    end else if (er) begin
      checkOutput("errSpurious", er, 0);
    end
  endtask

  // One clock: sample mid-cycle, then advance masters just after the edge
  task automatic run_cycle();
    logic d0, d1;
    @(negedge clk);
    smp_grant = grant; smp_read = s_read; smp_err0 = m0_err; smp_addr = s_address;
    monitor_master(0, d0);
    monitor_master(1, d1);
    @(posedge clk);
    #1;
    cycle++;
    if (d0 && m0_cmds.size() > 0) void'(m0_cmds.pop_front());
    if (d1 && m1_cmds.size() > 0) void'(m1_cmds.pop_front());
    applyStimulus();
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      run_cycle();
      n++;
    end
    checkOutput("drained", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    m0_cmds.delete(); m1_cmds.delete(); exp_q.delete();
    wait_mode = 0;
    applyStimulus();
    #1;
    checkOutput("rstSlave", {s_read, s_write, s_byteenable, s_address}, 0);
    checkOutput("rstWData", s_writedata, 0);
    checkOutput("rstM0", {m0_waitrequest, m0_err, m0_readdata}, {1'b1, 1'b0, 32'h0});
    checkOutput("rstM1", {m1_waitrequest, m1_err, m1_readdata}, {1'b1, 1'b0, 32'h0});
    checkOutput("rstGrant", grant, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    cmd_t cw, cr;
    int   stalls;
    logic seen_err;

    // Test 1: single M0 read, one-cycle arbitration latency from IDLE
    apply_reset();
    issue(0, 1'b0, 32'hBFC00000, 32'h0, 4'hF);
    run_cycle();
    checkOutput("t1GrantIdle", smp_grant, 2'b00);
    run_cycle();
    checkOutput("t1Grant", smp_grant, 2'b01);
    checkOutput("t1SRead", smp_read, 1'b1);
    checkOutput("t1SAddr", smp_addr, 32'hBFC00000);
    drain(5);

    // Test 2: both masters streaming, strict alternation with no idle gap
    apply_reset();
    check_gap = 1'b1; have_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, 32'h00000100 + 32'(i * 4), 32'h0, 4'hF);
      issue(1, 1'b1, 32'h00000200 + 32'(i * 4), 32'h11110000 + 32'(i), 4'hF);
    end
    drain(20);

    // Test 3: M1 alone, parked, back-to-back partial writes
    have_last = 1'b0;
    for (int i = 1; i <= 3; i++) issue(1, 1'b1, 32'h00000300 + 32'(i * 4), 32'hCAFE0000 + 32'(i), 4'b0011);
    drain(10);
    check_gap = 1'b0;

    // Test 4: M0 read against a stuck slave is aborted, then pending M1 is served
    set_wait(1);
    cr = mk_cmd(1'b0, 32'h00001000, 32'h0, 4'hF);
    m0_cmds.push_back(cr);
    push_exp(0, cr, 1'b1);
    applyStimulus();
    stalls = 0;
    seen_err = 1'b0;
    for (int i = 0; i < 40 && !seen_err; i++) begin
      run_cycle();
      if (i == 3) issue(1, 1'b0, 32'h00003000, 32'h0, 4'hF);
      if (smp_err0) begin
        seen_err = 1'b1;
        checkOutput("t4Stalls", stalls, TO);
        checkOutput("t4SRead", smp_read, 1'b0);
        set_wait(0);
      end else if (smp_grant == 2'b01) begin
        stalls++;
      end
    end
    checkOutput("t4Abort", seen_err, 1'b1);
    run_cycle();
    checkOutput("t4ErrPulse", smp_err0, 1'b0);
    checkOutput("t4NextGrant", smp_grant, 2'b10);
    drain(10);

    // Test 5: asynchronous reset during a stalled M1 write
    set_wait(1);
    cw = mk_cmd(1'b1, 32'h00002000, 32'h5555AAAA, 4'hF);
    m1_cmds.push_back(cw);
    applyStimulus();
    for (int i = 0; i < 3; i++) run_cycle();
    checkOutput("t5Owner", smp_grant, 2'b10);
    reset = 1'b0;
    #1;
    checkOutput("t5SWrite", s_write, 1'b0);
    checkOutput("t5Grant", grant, 2'b00);
    checkOutput("t5Wait1", m1_waitrequest, 1'b1);
    cr = mk_cmd(1'b0, 32'h00004000, 32'h0, 4'hF);
    m0_cmds.push_back(cr);
    push_exp(0, cr, 1'b0);
    push_exp(1, cw, 1'b0);
    set_wait(0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drain(10);

    // Test 6: alternating slave stall with both masters reading
    set_wait(2);
    for (int i = 0; i < 3; i++) begin
      issue(1, 1'b0, 32'h00006000 + 32'(i * 4), 32'h0, 4'hF);
      issue(0, 1'b0, 32'h00005000 + 32'(i * 4), 32'h0, 4'hF);
    end
    drain(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
